// File: rtl/addr_stepper.sv
// addr_stepper: debounced up/down/mode push-buttons with hold-to-repeat,
// driving the ShowMem/Addr selection consumed by the seven-segment display block.

module addr_stepper #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_DELAY    = 50_000_000,
   parameter int REPEAT_RATE     = 10_000_000
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_mode,
   output logic       ShowMem,
   output logic [5:0] Addr,
   output logic       Changed
);

   localparam int NBTN     = 3;
   localparam int NREP     = 2;
   localparam int BTN_UP   = 0;
   localparam int BTN_DOWN = 1;
   localparam int BTN_MODE = 2;

   localparam int DW      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW      = $clog2(REP_MAX + 1);

   localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] DELAY_LAST = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
   localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);
   localparam bit            REP_ON     = (REPEAT_DELAY > 0);

   typedef enum logic [1:0] {
      REP_IDLE,
      REP_WAIT,
      REP_RUN
   } repState_t;

   logic [NBTN-1:0] w_btnRaw;
   logic [NBTN-1:0] r_sync1;
   logic [NBTN-1:0] r_sync2;
   logic [NBTN-1:0] r_stable;
   logic [NBTN-1:0] r_press;
   logic [DW-1:0]   r_debCnt [NBTN];
   logic [NBTN-1:0] w_differ;
   logic [NBTN-1:0] w_accept;
   logic [NBTN-1:0] w_rise;

   repState_t       r_repState     [NREP];
   repState_t       w_repStateNext [NREP];
   logic [RW-1:0]   r_repCnt       [NREP];
   logic [RW-1:0]   w_repCntNext   [NREP];
   logic [NREP-1:0] r_repPulse;
   logic [NREP-1:0] w_repPulseNext;

   logic            w_upEvt;
   logic            w_downEvt;
   logic            w_modeEvt;
   logic            r_showMem;
   logic [5:0]      r_addr;
   logic            r_changed;
   logic            w_nextShowMem;
   logic [5:0]      w_nextAddr;
   logic            w_update;

   assign w_btnRaw = {btn_mode, btn_down, btn_up};

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= w_btnRaw;
         r_sync2 <= r_sync1;
      end
   end

   // A level change is accepted on the edge where it has disagreed with the
   // current stable level for DEBOUNCE_CYCLES consecutive samples.
   always_comb begin
      w_differ = '0;
      w_accept = '0;
      w_rise   = '0;
      for (int i = 0; i < NBTN; i++) begin
         w_differ[i] = (r_sync2[i] != r_stable[i]);
         w_accept[i] = w_differ[i] && (r_debCnt[i] == DEB_LAST);
         w_rise[i]   = w_accept[i] && r_sync2[i];
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_stable <= '0;
         r_press  <= '0;
         for (int i = 0; i < NBTN; i++) begin
            r_debCnt[i] <= '0;
         end
      end else begin
         r_press <= w_rise;
         for (int i = 0; i < NBTN; i++) begin
            if (!w_differ[i]) begin
               r_debCnt[i] <= '0;
            end else if (w_accept[i]) begin
               r_stable[i] <= r_sync2[i];
               r_debCnt[i] <= '0;
            end else begin
               r_debCnt[i] <= r_debCnt[i] + DW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_repPulse <= '0;
         for (int i = 0; i < NREP; i++) begin
            r_repState[i] <= REP_IDLE;
            r_repCnt[i]   <= '0;
         end
      end else begin
         r_repPulse <= w_repPulseNext;
         for (int i = 0; i < NREP; i++) begin
            r_repState[i] <= w_repStateNext[i];
            r_repCnt[i]   <= w_repCntNext[i];
         end
      end
   end

   // Repeat timer: a fresh press always restarts the delay, even if the
   // previous hold's release is still being seen by the state machine.
   always_comb begin
      w_repPulseNext = '0;
      for (int i = 0; i < NREP; i++) begin
         w_repStateNext[i] = r_repState[i];
         w_repCntNext[i]   = r_repCnt[i];
         if (w_rise[i]) begin
            w_repCntNext[i] = '0;
            if (REP_ON) begin
               w_repStateNext[i] = REP_WAIT;
            end else begin
               w_repStateNext[i] = REP_IDLE;
            end
         end else begin
            case (r_repState[i])
               REP_WAIT: begin
                  if (!r_stable[i]) begin
                     w_repStateNext[i] = REP_IDLE;
                     w_repCntNext[i]   = '0;
                  end else if (r_repCnt[i] == DELAY_LAST) begin
                     w_repPulseNext[i] = 1'b1;
                     w_repStateNext[i] = REP_RUN;
                     w_repCntNext[i]   = '0;
                  end else begin
                     w_repCntNext[i] = r_repCnt[i] + RW'(1);
                  end
               end
               REP_RUN: begin
                  if (!r_stable[i]) begin
                     w_repStateNext[i] = REP_IDLE;
                     w_repCntNext[i]   = '0;
                  end else if (r_repCnt[i] == RATE_LAST) begin
                     w_repPulseNext[i] = 1'b1;
                     w_repCntNext[i]   = '0;
                  end else begin
                     w_repCntNext[i] = r_repCnt[i] + RW'(1);
                  end
               end
               default: begin
                  w_repStateNext[i] = REP_IDLE;
                  w_repCntNext[i]   = '0;
               end
            endcase
         end
      end
   end

   assign w_upEvt   = r_press[BTN_UP]   | r_repPulse[BTN_UP];
   assign w_downEvt = r_press[BTN_DOWN] | r_repPulse[BTN_DOWN];
   assign w_modeEvt = r_press[BTN_MODE];

   // Mode wins over steps; register view keeps Addr[5] at zero by wrapping mod 32.
   always_comb begin
      w_nextShowMem = r_showMem;
      w_nextAddr    = r_addr;
      w_update      = 1'b0;
      if (w_modeEvt) begin
         w_nextShowMem = ~r_showMem;
         w_nextAddr    = '0;
         w_update      = 1'b1;
      end else if (w_upEvt && !w_downEvt) begin
         w_update = 1'b1;
         if (r_showMem) begin
            w_nextAddr = r_addr + 6'd1;
         end else begin
            w_nextAddr = {1'b0, r_addr[4:0] + 5'd1};
         end
      end else if (w_downEvt && !w_upEvt) begin
         w_update = 1'b1;
         if (r_showMem) begin
            w_nextAddr = r_addr - 6'd1;
         end else begin
            w_nextAddr = {1'b0, r_addr[4:0] - 5'd1};
         end
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_showMem <= 1'b0;
         r_addr    <= '0;
         r_changed <= 1'b0;
      end else begin
         r_showMem <= w_nextShowMem;
         r_addr    <= w_nextAddr;
         r_changed <= w_update;
      end
   end

   assign ShowMem = r_showMem;
   assign Addr    = r_addr;
   assign Changed = r_changed;

endmodule

// File: tb/tb_addr_stepper.sv
// Bench for addr_stepper: directed front-panel scenarios and randomized button
// activity, with a scoreboard fed by a behavioural model of the button rules.
`timescale 1ns/1ps

module tb_addr_stepper;

   localparam int D  = 4;
   localparam int RD = 20;
   localparam int RR = 5;

   logic       clk     = 1'b0;
   logic       clr     = 1'b0;
   logic       btnUp   = 1'b0;
   logic       btnDown = 1'b0;
   logic       btnMode = 1'b0;
   logic       showMem;
   logic [5:0] addr;
   logic       changed;

   typedef struct {
      int cyc;
      int a;
      bit m;
   } expect_t;

   expect_t expQ[$];

   int vectors     = 0;
   int miscompares = 0;
   int cycle       = 0;

   bit hist [3][D+2];
   bit mStable [3];
   int mPressCyc [3];
   bit pend [3];
   int mAddr = 0;
   bit mShow = 1'b0;
   int lastA = 0;
   bit lastM = 1'b0;

   addr_stepper #(
      .DEBOUNCE_CYCLES(D),
      .REPEAT_DELAY(RD),
      .REPEAT_RATE(RR)
   ) dut (
      .clk(clk),
      .clr(clr),
      .btn_up(btnUp),
      .btn_down(btnDown),
      .btn_mode(btnMode),
      .ShowMem(showMem),
      .Addr(addr),
      .Changed(changed)
   );

   initial forever #5 clk = ~clk;

   // A held button steps at RD cycles after its press, then every RR cycles.
   function automatic bit repeatDue(input int held);
      return (held == RD) || ((held > RD) && (((held - RD) % RR) == 0));
   endfunction

   // Reference model: a button level is accepted once the synchronized samples
   // (raw delayed two edges) of the last D edges all disagree with it.
   initial begin : model
      bit rawNow [3];
      bit pulse [3];
      bit allDiffer;
      int modulus;
      forever begin
         @(posedge clk);
         cycle = cycle + 1;
         if (!clr) begin
            for (int b = 0; b < 3; b++) begin
               for (int i = 0; i < D + 2; i++) hist[b][i] = 1'b0;
               mStable[b]   = 1'b0;
               pend[b]      = 1'b0;
               mPressCyc[b] = 0;
            end
            mAddr = 0;
            mShow = 1'b0;
         end else begin
            rawNow[0] = btnUp;
            rawNow[1] = btnDown;
            rawNow[2] = btnMode;
            for (int b = 0; b < 3; b++) begin
               for (int i = D + 1; i > 0; i--) hist[b][i] = hist[b][i-1];
               hist[b][0] = rawNow[b];
               pulse[b] = (b != 2) && mStable[b] && repeatDue(cycle - mPressCyc[b]);
               allDiffer = 1'b1;
               for (int j = 2; j < D + 2; j++) begin
                  if (hist[b][j] == mStable[b]) allDiffer = 1'b0;
               end
               if (allDiffer) begin
                  mStable[b] = !mStable[b];
                  if (mStable[b]) begin
                     pulse[b]     = 1'b1;
                     mPressCyc[b] = cycle;
                  end
               end
            end
            modulus = mShow ? 64 : 32;
            if (pend[2]) begin
               mShow = !mShow;
               mAddr = 0;
               expQ.push_back('{cyc: cycle, a: mAddr, m: mShow});
            end else if (pend[0] != pend[1]) begin
               if (pend[0]) mAddr = (mAddr + 1) % modulus;
               else         mAddr = (mAddr + modulus - 1) % modulus;
               expQ.push_back('{cyc: cycle, a: mAddr, m: mShow});
            end
            for (int b = 0; b < 3; b++) pend[b] = pulse[b];
         end
      end
   end

   // Monitor: every Changed pulse consumes one expected update; otherwise the
   // outputs must hold the last confirmed value.
   initial begin : monitor
      expect_t e;
      forever begin
         @(negedge clk);
         vectors++;
         if (!clr) begin
            if (addr !== 6'd0 || showMem !== 1'b0 || changed !== 1'b0) begin
               miscompares++;
               $display("[TB] FAIL resetHold: got Addr=%0d ShowMem=%b Changed=%b, want 0 0 0", addr, showMem, changed);
            end
            lastA = 0;
            lastM = 1'b0;
         end else if (changed === 1'b1) begin
            if (expQ.size() == 0) begin
               miscompares++;
               $display("[TB] FAIL spuriousChanged: got Addr=%0d ShowMem=%b at cycle %0d, want no update", addr, showMem, cycle);
            end else begin
               e = expQ.pop_front();
               if (addr !== 6'(e.a) || showMem !== e.m || cycle != e.cyc) begin
                  miscompares++;
                  $display("[TB] FAIL update: got Addr=%0d ShowMem=%b at cycle %0d, want Addr=%0d ShowMem=%b at cycle %0d",
                           addr, showMem, cycle, e.a, e.m, e.cyc);
               end
               lastA = e.a;
               lastM = e.m;
            end
         end else if (addr !== 6'(lastA) || showMem !== lastM) begin
            miscompares++;
            $display("[TB] FAIL holdValue: got Addr=%0d ShowMem=%b at cycle %0d, want Addr=%0d ShowMem=%b",
                     addr, showMem, cycle, lastA, lastM);
         end
      end
   end

   task automatic applyStimulus(input bit u, input bit d, input bit m, input int n);
      btnUp   = u;
      btnDown = d;
      btnMode = m;
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input bit u, input bit d, input bit m);
      applyStimulus(u, d, m, 10);
      applyStimulus(1'b0, 1'b0, 1'b0, 12);
   endtask

   task automatic checkOutput(input string name, input int expA, input bit expM, input bit expC);
      vectors++;
      if (addr !== 6'(expA) || showMem !== expM || changed !== expC) begin
         miscompares++;
         $display("[TB] FAIL %s: got Addr=%0d ShowMem=%b Changed=%b, want Addr=%0d ShowMem=%b Changed=%b",
                  name, addr, showMem, changed, expA, expM, expC);
      end
   endtask

   task automatic pulseReset();
      @(negedge clk);
      #2 clr = 1'b0;
      repeat (2) @(negedge clk);
      #2 clr = 1'b1;
      @(negedge clk);
   endtask

   initial begin : stimulus
      logic [2:0] mask;
      int         n;

      repeat (3) @(negedge clk);
      checkOutput("resetState", 0, 1'b0, 1'b0);
      #2 clr = 1'b1;
      @(negedge clk);

      $display("[TB] first press latency");
      applyStimulus(1'b1, 1'b0, 1'b0, 6);
      checkOutput("beforeFirstStep", 0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1);
      checkOutput("firstStep", 1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 3);
      applyStimulus(1'b0, 1'b0, 1'b0, 12);

      $display("[TB] bounce rejection");
      applyStimulus(1'b1, 1'b0, 1'b0, 2);
      applyStimulus(1'b0, 1'b0, 1'b0, 2);
      applyStimulus(1'b1, 1'b0, 1'b0, 2);
      applyStimulus(1'b0, 1'b0, 1'b0, 2);
      applyStimulus(1'b1, 1'b0, 1'b0, 3);
      applyStimulus(1'b0, 1'b0, 1'b0, 12);
      checkOutput("bounceIgnored", 1, 1'b0, 1'b0);

      $display("[TB] wrap-around");
      press(1'b0, 1'b1, 1'b0);
      press(1'b0, 1'b1, 1'b0);
      checkOutput("regWrapDown", 31, 1'b0, 1'b0);
      press(1'b1, 1'b0, 1'b0);
      checkOutput("regWrapUp", 0, 1'b0, 1'b0);
      press(1'b0, 1'b0, 1'b1);
      checkOutput("modeToMem", 0, 1'b1, 1'b0);
      press(1'b0, 1'b1, 1'b0);
      checkOutput("memWrapDown", 63, 1'b1, 1'b0);
      press(1'b1, 1'b0, 1'b0);
      checkOutput("memWrapUp", 0, 1'b1, 1'b0);
      press(1'b0, 1'b0, 1'b1);

      $display("[TB] hold-to-repeat");
      for (int i = 0; i < 5; i++) press(1'b1, 1'b0, 1'b0);
      checkOutput("upToFive", 5, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 38);
      checkOutput("repeatMid", 1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 30);
      checkOutput("repeatFinal", 0, 1'b0, 1'b0);

      $display("[TB] simultaneous events");
      for (int i = 0; i < 7; i++) press(1'b1, 1'b0, 1'b0);
      checkOutput("upToSeven", 7, 1'b0, 1'b0);
      press(1'b1, 1'b1, 1'b0);
      checkOutput("upDownCancel", 7, 1'b0, 1'b0);
      press(1'b1, 1'b0, 1'b1);
      checkOutput("modeOverridesUp", 0, 1'b1, 1'b0);
      press(1'b1, 1'b0, 1'b0);
      checkOutput("memStep", 1, 1'b1, 1'b0);

      $display("[TB] reset during debounce");
      applyStimulus(1'b1, 1'b0, 1'b0, 4);
      #2 clr = 1'b0;
      #1 checkOutput("asyncReset", 0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      #2 clr = 1'b1;
      repeat (6) @(negedge clk);
      checkOutput("reheldBefore", 0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("reheldStep", 1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 3);
      applyStimulus(1'b0, 1'b0, 1'b0, 12);

      $display("[TB] randomized buttons");
      for (int it = 0; it < 120; it++) begin
         mask = 3'($urandom_range(0, 7));
         n    = $urandom_range(1, 45);
         applyStimulus(mask[0], mask[1], mask[2], n);
         if ($urandom_range(0, 24) == 0) pulseReset();
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 60);

      #1;
      vectors++;
      if (expQ.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL scoreboardDrained: got %0d pending updates, want 0", expQ.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
